// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register engine: command ops, FSM states, cell modes.
// USR_ROTATE_EN selects whether op 11 means HOLD or ROTR.
package usr_pkg;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SHR  = 2'b01;
   localparam logic [1:0] OP_SHL  = 2'b10;
   localparam logic [1:0] OP_HOLD = 2'b11;
   localparam logic [1:0] OP_ROTR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_RIGHT = 2'b01,
      MODE_LEFT  = 2'b10,
      MODE_LOAD  = 2'b11
   } mode_t;

endpackage

// File: rtl/usr_cell.sv
// One bit of the universal shift register: a 4:1 mode mux in front of an async-reset flop.
module usr_cell
   import usr_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  mode_t mode_i,
   input  logic  right_in_i,
   input  logic  left_in_i,
   input  logic  load_in_i,
   output logic  q_o
);

   logic bit_d;
   logic bit_q;

   always_comb begin
      bit_d = bit_q;
      case (mode_i)
         MODE_HOLD:  bit_d = bit_q;
         MODE_RIGHT: bit_d = right_in_i;
         MODE_LEFT:  bit_d = left_in_i;
         MODE_LOAD:  bit_d = load_in_i;
         default:    bit_d = bit_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bit_q <= 1'b0;
      else        bit_q <= bit_d;
   end

   assign q_o = bit_q;

endmodule

// File: rtl/usr_shift_engine.sv
// Command-driven USR controller: LOAD / SHR / SHL / HOLD over valid-ready, one shift bit per clock.
// Define USR_ROTATE_EN to turn op 11 into a multi-bit rotate right (ROTR).
module usr_shift_engine
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CW-1:0]    cmd_cnt,
   input  logic [WIDTH-1:0] par_in,
   input  logic             ser_in_msb,
   input  logic             ser_in_lsb,
   output logic [WIDTH-1:0] q,
   output logic             ser_out_lsb,
   output logic             ser_out_msb,
   output logic             busy,
   output logic             done
);

   state_t          state_q;
   logic [CW-1:0]   rem_q;
   logic [1:0]      op_q;
   mode_t           mode;
   logic            accept;
   logic            is_shift_op;
   logic            msb_src;
   logic [CW-1:0]   eff_cnt;

   assign accept  = cmd_valid && (state_q == ST_IDLE);
   assign eff_cnt = (cmd_cnt > CW'(WIDTH)) ? CW'(WIDTH) : cmd_cnt;

`ifdef USR_ROTATE_EN
   assign is_shift_op = (cmd_op == OP_SHR) || (cmd_op == OP_SHL) || (cmd_op == OP_ROTR);
   assign msb_src     = (op_q == OP_ROTR) ? q[0] : ser_in_msb;
`else
   assign is_shift_op = (cmd_op == OP_SHR) || (cmd_op == OP_SHL);
   assign msb_src     = ser_in_msb;
`endif

   // Only shift ops are latched into op_q, so anything other than SHL steps right.
   always_comb begin
      mode = MODE_HOLD;
      if (accept && (cmd_op == OP_LOAD))
         mode = MODE_LOAD;
      else if (state_q == ST_SHIFT)
         mode = (op_q == OP_SHL) ? MODE_LEFT : MODE_RIGHT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         op_q    <= OP_LOAD;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (is_shift_op && (eff_cnt != '0)) begin
                     rem_q   <= eff_cnt;
                     op_q    <= cmd_op;
                     state_q <= ST_SHIFT;
                  end else begin
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               rem_q <= rem_q - CW'(1);
               if (rem_q == CW'(1)) state_q <= ST_DONE;
            end
            ST_DONE:  state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic right_in;
      logic left_in;
      if (gi == WIDTH - 1) begin : g_top
         assign right_in = msb_src;
      end else begin : g_mid_r
         assign right_in = q[gi+1];
      end
      if (gi == 0) begin : g_bot
         assign left_in = ser_in_lsb;
      end else begin : g_mid_l
         assign left_in = q[gi-1];
      end
      usr_cell u_cell (
         .clk        (clk),
         .rst_n      (rst_n),
         .mode_i     (mode),
         .right_in_i (right_in),
         .left_in_i  (left_in),
         .load_in_i  (par_in[gi]),
         .q_o        (q[gi])
      );
   end

   assign cmd_ready   = (state_q == ST_IDLE);
   assign busy        = (state_q == ST_SHIFT);
   assign done        = (state_q == ST_DONE);
   assign ser_out_lsb = q[0];
   assign ser_out_msb = q[WIDTH-1];

endmodule

// File: tb/tb_usr_shift_engine.sv
// Directed self-checking bench for usr_shift_engine (WIDTH=8); honours USR_ROTATE_EN for op 11.
module tb_usr_shift_engine;

   localparam int WIDTH = 8;
   localparam int CW    = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = 2'b00;
   logic [CW-1:0]    cmd_cnt = '0;
   logic [WIDTH-1:0] par_in = '0;
   logic             ser_in_msb = 1'b0;
   logic             ser_in_lsb = 1'b0;
   logic [WIDTH-1:0] q;
   logic             ser_out_lsb;
   logic             ser_out_msb;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   usr_shift_engine #(.WIDTH(WIDTH), .CW(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_cnt     (cmd_cnt),
      .par_in      (par_in),
      .ser_in_msb  (ser_in_msb),
      .ser_in_lsb  (ser_in_lsb),
      .q           (q),
      .ser_out_lsb (ser_out_lsb),
      .ser_out_msb (ser_out_msb),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // Present a command at a negedge; returns at the next negedge (accept edge has passed).
   task automatic send(input logic [1:0] op, input logic [CW-1:0] cnt, input logic [WIDTH-1:0] par);
      cmd_op    = op;
      cmd_cnt   = cnt;
      par_in    = par;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic load_and_settle(input logic [WIDTH-1:0] val);
      send(2'b00, '0, val);
      @(negedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", q); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
      // Abort a 5-bit SHR mid-flight
      load_and_settle(8'hF0);
      ser_in_msb = 1'b1;
      send(2'b01, 4'd5, 8'h00);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midshift_busy got %b want 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (q !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL midshift_reset got q=%h busy=%b want q=00 busy=0", q, busy); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++; if (done !== 1'b0 || q !== 8'h00) begin errors++; $display("FAIL abort_no_done cycle %0d got done=%b q=%h want done=0 q=00", i, done, q); end
      end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_abort_ready got %b want 1", cmd_ready); end
      ser_in_msb = 1'b0;
      $display("test_reset done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_load;
      send(2'b00, 4'd7, 8'hA5);
      checks++; if (q !== 8'hA5) begin errors++; $display("FAIL load_q got %h want a5", q); end
      checks++; if (done !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL load_done got done=%b ready=%b want 1 0", done, cmd_ready); end
      checks++; if (ser_out_lsb !== 1'b1 || ser_out_msb !== 1'b1) begin errors++; $display("FAIL load_serout got %b%b want 11", ser_out_msb, ser_out_lsb); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL load_done_pulse got done=%b ready=%b want 0 1", done, cmd_ready); end
      $display("test_load done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_shr;
      logic [WIDTH-1:0] exp_q [0:3];
      int busy_cycles;
      exp_q[0] = 8'hA5; exp_q[1] = 8'hD2; exp_q[2] = 8'hE9; exp_q[3] = 8'hF4;
      busy_cycles = 0;
      ser_in_msb = 1'b1;
      send(2'b01, 4'd3, 8'h00);
      for (int k = 0; k < 4; k++) begin
         checks++; if (q !== exp_q[k]) begin errors++; $display("FAIL shr_step%0d got %h want %h", k, q, exp_q[k]); end
         if (busy === 1'b1) busy_cycles++;
         if (k < 3) begin
            checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL shr_busy%0d got busy=%b done=%b want 1 0", k, busy, done); end
         end else begin
            checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL shr_done got busy=%b done=%b want 0 1", busy, done); end
         end
         @(negedge clk);
      end
      checks++; if (busy_cycles !== 3) begin errors++; $display("FAIL shr_busy_count got %0d want 3", busy_cycles); end
      ser_in_msb = 1'b0;
      $display("test_shr done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_shl_saturate;
      logic [WIDTH-1:0] exp_q;
      int busy_cycles;
      load_and_settle(8'hFF);
      ser_in_lsb = 1'b0;
      send(2'b10, 4'd12, 8'h00);
      busy_cycles = (busy === 1'b1) ? 1 : 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp_q = 8'hFF << k;
         checks++; if (q !== exp_q || ser_out_msb !== exp_q[7]) begin errors++; $display("FAIL shl_step%0d got q=%h msb=%b want q=%h msb=%b", k, q, ser_out_msb, exp_q, exp_q[7]); end
         if (busy === 1'b1) busy_cycles++;
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL shl_done got %b want 1", done); end
      checks++; if (busy_cycles !== 8) begin errors++; $display("FAIL shl_busy_count got %0d want 8", busy_cycles); end
      @(negedge clk);
      $display("test_shl_saturate done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_zero_count;
      load_and_settle(8'h3C);
      send(2'b10, 4'd0, 8'hFF);
      checks++; if (q !== 8'h3C || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_cnt got q=%h done=%b busy=%b want 3c 1 0", q, done, busy); end
      @(negedge clk);
      $display("test_zero_count done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_back_to_back;
      // q=3C, SHR by 2 with 0 in, then a LOAD held valid while the engine is busy
      ser_in_msb = 1'b0;
      send(2'b01, 4'd2, 8'h00);
      cmd_op = 2'b00; cmd_cnt = 4'd9; par_in = 8'h11; cmd_valid = 1'b1;
      @(negedge clk);
      checks++; if (q !== 8'h1E) begin errors++; $display("FAIL held_step1 got %h want 1e", q); end
      @(negedge clk);
      checks++; if (q !== 8'h0F || done !== 1'b1) begin errors++; $display("FAIL held_done got q=%h done=%b want 0f 1", q, done); end
      @(negedge clk);
      checks++; if (q !== 8'h0F || cmd_ready !== 1'b1) begin errors++; $display("FAIL held_not_early got q=%h ready=%b want 0f 1", q, cmd_ready); end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++; if (q !== 8'h11 || done !== 1'b1) begin errors++; $display("FAIL held_load got q=%h done=%b want 11 1", q, done); end
      @(negedge clk);
      $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_op11;
      load_and_settle(8'h81);
      ser_in_msb = 1'b0;
      send(2'b11, 4'd1, 8'h00);
`ifdef USR_ROTATE_EN
      checks++; if (busy !== 1'b1 || q !== 8'h81) begin errors++; $display("FAIL rotr_accept got busy=%b q=%h want 1 81", busy, q); end
      @(negedge clk);
      checks++; if (q !== 8'hC0 || done !== 1'b1) begin errors++; $display("FAIL rotr_result got q=%h done=%b want c0 1", q, done); end
`else
      checks++; if (busy !== 1'b0 || done !== 1'b1 || q !== 8'h81) begin errors++; $display("FAIL hold_result got busy=%b done=%b q=%h want 0 1 81", busy, done, q); end
`endif
      @(negedge clk);
      $display("test_op11 done: checks=%0d errors=%0d", checks, errors);
   endtask

   initial begin
      test_reset();
      test_load();
      test_shr();
      test_shl_saturate();
      test_zero_count();
      test_back_to_back();
      test_op11();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
